// File: rtl/vga_pixel_feeder_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_feeder_if
// Bundles the scanner write port, the VGA request/answer port and the status
// outputs of vga_pixel_feeder.
//   slave  : the feeder side (consumes writes and requests, drives answers)
//   master : the environment side (scanner + VGA timing block)
// Signals:
//   iWR_VALID, iWR_SOF, iWR_R/G/B  scanner pixel and start-of-frame tag
//   oWR_READY                      FIFO not full
//   iRequest                       per-pixel request from VGA timing
//   oVGA_R/G/B, oPixValid          registered pixel answer
//   oFrameDone                     pulse with the last answer of a frame
//   oUnderflow, oSyncErr           sticky error flags
//   oFill                          FIFO occupancy (FIFO_AW+1 bits)
// -----------------------------------------------------------------------------
interface vga_pixel_feeder_if #(
  parameter int FIFO_AW = 9
);
  logic             iWR_VALID;
  logic             iWR_SOF;
  logic [7:0]       iWR_R;
  logic [7:0]       iWR_G;
  logic [7:0]       iWR_B;
  logic             oWR_READY;
  logic             iRequest;
  logic [7:0]       oVGA_R;
  logic [7:0]       oVGA_G;
  logic [7:0]       oVGA_B;
  logic             oPixValid;
  logic             oFrameDone;
  logic             oUnderflow;
  logic             oSyncErr;
  logic [FIFO_AW:0] oFill;

  modport slave (
    input  iWR_VALID, iWR_SOF, iWR_R, iWR_G, iWR_B, iRequest,
    output oWR_READY, oVGA_R, oVGA_G, oVGA_B, oPixValid, oFrameDone,
           oUnderflow, oSyncErr, oFill
  );

  modport master (
    output iWR_VALID, iWR_SOF, iWR_R, iWR_G, iWR_B, iRequest,
    input  oWR_READY, oVGA_R, oVGA_G, oVGA_B, oPixValid, oFrameDone,
           oUnderflow, oSyncErr, oFill
  );
endinterface

// File: rtl/vga_pixel_feeder.sv
// -----------------------------------------------------------------------------
// vga_pixel_feeder
// Pixel source for the VGA timing block. Scanner pixels (with a start-of-frame
// tag) are buffered in a 2^FIFO_AW x 25-bit FIFO; each iRequest is answered one
// cycle later with the head pixel. A SEEK/RUN/WAIT state machine keeps scanner
// frames aligned to screen frames and substitutes UNDER_COLOR on underflow or
// misalignment.
// Ports:
//   iCLK25     pixel clock, all logic on its rising edge
//   iRST       synchronous active-high reset
//   iTestMode  colour-bar test pattern select (only with FEEDER_TESTPATTERN_EN)
//   bus        vga_pixel_feeder_if.slave (write port, request/answer, status)
// Build option:
//   FEEDER_TESTPATTERN_EN  adds iTestMode and the 8-bar test pattern.
// -----------------------------------------------------------------------------
module vga_pixel_feeder #(
  parameter int          FIFO_AW     = 9,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [23:0] UNDER_COLOR = 24'h000000
) (
  input logic               iCLK25,
  input logic               iRST,
`ifdef FEEDER_TESTPATTERN_EN
  input logic               iTestMode,
`endif
  vga_pixel_feeder_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  logic [24:0]        mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   fill_r;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   row_r;
  state_t             state_r;
  state_t             state_next_s;

  logic [24:0]        head_s;
  logic               head_sof_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               at_bound_s;
  logic               last_pix_s;
  logic               set_under_s;
  logic               set_sync_s;
  logic [23:0]        answer_s;

  logic [23:0]        rgb_r;
  logic               pix_valid_r;
  logic               frame_done_r;
  logic               underflow_r;
  logic               sync_err_r;

`ifdef FEEDER_TESTPATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  // Colour of the vertical bar containing column col (white .. black).
  function automatic logic [23:0] bar_color(input logic [COL_W-1:0] col);
    int q;
    logic [2:0] idx;
    q = int'(col) / BAR_W;
    idx = (q > 7) ? 3'd7 : 3'(q);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction
`endif

  // Full is the extra occupancy MSB: occupancy can only reach 2^FIFO_AW there.
  assign full_s     = fill_r[FIFO_AW];
  assign empty_s    = (fill_r == '0);
  assign push_s     = bus.iWR_VALID & ~full_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign head_sof_s = head_s[24];
  assign at_bound_s = (col_r == COL_W'(0)) && (row_r == ROW_W'(0));
  assign last_pix_s = (col_r == COL_W'(H_ACTIVE - 1)) && (row_r == ROW_W'(V_ACTIVE - 1));

  // FIFO storage write port (contents need no reset; pointers define validity).
  always_ff @(posedge iCLK25) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.iWR_SOF, bus.iWR_R, bus.iWR_G, bus.iWR_B};
    end
  end

  // FIFO pointers and occupancy; reset overrides a simultaneous write.
  always_ff @(posedge iCLK25) begin
    if (iRST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + (FIFO_AW + 1)'(1);
        2'b01:   fill_r <= fill_r - (FIFO_AW + 1)'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

  // Screen position: advances on every request regardless of state.
  always_ff @(posedge iCLK25) begin
    if (iRST) begin
      col_r <= '0;
      row_r <= '0;
    end else if (bus.iRequest) begin
      if (col_r == COL_W'(H_ACTIVE - 1)) begin
        col_r <= '0;
        row_r <= (row_r == ROW_W'(V_ACTIVE - 1)) ? ROW_W'(0) : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Alignment state register.
  always_ff @(posedge iCLK25) begin
    if (iRST) state_r <= ST_SEEK;
    else      state_r <= state_next_s;
  end

  // Next state, pop decision, answer colour and error strobes.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    answer_s     = UNDER_COLOR;
    set_under_s  = 1'b0;
    set_sync_s   = 1'b0;
    case (state_r)
      ST_SEEK: begin
        if (empty_s) begin
          set_under_s = bus.iRequest;
        end else if (!head_sof_s) begin
          // Drop stale data until a frame start reaches the head.
          pop_s = 1'b1;
        end else if (bus.iRequest && at_bound_s) begin
          pop_s        = 1'b1;
          answer_s     = head_s[23:0];
          state_next_s = ST_RUN;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (!bus.iRequest) begin
          pop_s = 1'b0;
        end else if (empty_s) begin
          set_under_s = 1'b1;
        end else if (head_sof_s && !at_bound_s) begin
          // Scanner frame ended early: hold its SOF until the screen catches up.
          set_sync_s   = 1'b1;
          state_next_s = ST_WAIT;
        end else if (at_bound_s && !head_sof_s) begin
          // Screen frame started but scanner data is mid-frame: resynchronise.
          set_sync_s   = 1'b1;
          state_next_s = ST_SEEK;
        end else begin
          pop_s    = 1'b1;
          answer_s = head_s[23:0];
        end
      end
      ST_WAIT: begin
        if (bus.iRequest && at_bound_s) begin
          if (empty_s) begin
            set_under_s = 1'b1;
          end else begin
            pop_s        = 1'b1;
            answer_s     = head_s[23:0];
            state_next_s = ST_RUN;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_SEEK;
      end
    endcase
`ifdef FEEDER_TESTPATTERN_EN
    if (iTestMode) begin
      state_next_s = ST_SEEK;
      pop_s        = 1'b0;
      set_under_s  = 1'b0;
      set_sync_s   = 1'b0;
      answer_s     = bar_color(col_r);
    end else begin
      answer_s = answer_s;
    end
`endif
  end

  // Registered answer, frame-done pulse and sticky error flags.
  always_ff @(posedge iCLK25) begin
    if (iRST) begin
      rgb_r        <= '0;
      pix_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      underflow_r  <= 1'b0;
      sync_err_r   <= 1'b0;
    end else begin
      pix_valid_r  <= bus.iRequest;
      frame_done_r <= bus.iRequest & last_pix_s;
      if (bus.iRequest) rgb_r <= answer_s;
      if (set_under_s)  underflow_r <= 1'b1;
      if (set_sync_s)   sync_err_r  <= 1'b1;
    end
  end

  assign bus.oWR_READY  = ~full_s;
  assign bus.oVGA_R     = rgb_r[23:16];
  assign bus.oVGA_G     = rgb_r[15:8];
  assign bus.oVGA_B     = rgb_r[7:0];
  assign bus.oPixValid  = pix_valid_r;
  assign bus.oFrameDone = frame_done_r;
  assign bus.oUnderflow = underflow_r;
  assign bus.oSyncErr   = sync_err_r;
  assign bus.oFill      = fill_r;

endmodule
